// File: rtl/sincos_pkg.sv
// Shared constants, tag type and phase-wrap helper for the sincos arbiter.
package sincos_pkg;

  localparam int unsigned PHASE_W_DEF = 16;
  localparam int unsigned WRAP_W      = 17;

  // Q3.13 radians held in 17-bit signed so a single +/-2pi correction cannot overflow
  localparam logic signed [WRAP_W-1:0] PI_POS = 17'sh06488;
  localparam logic signed [WRAP_W-1:0] PI_NEG = -17'sh06488;
  localparam logic signed [WRAP_W-1:0] TWO_PI = PI_POS - PI_NEG;

  typedef enum logic {
    TAG_PLAYER = 1'b0,
    TAG_RAY    = 1'b1
  } tag_t;

  function automatic logic [PHASE_W_DEF-1:0] wrap_phase(input logic [PHASE_W_DEF-1:0] phase);
    logic signed [WRAP_W-1:0] p;
    p = $signed({phase[PHASE_W_DEF-1], phase});
    if (p > PI_POS) begin
      p = p - TWO_PI;
    end else if (p < PI_NEG) begin
      p = p + TWO_PI;
    end
    return p[PHASE_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/sincos_tag_fifo.sv
// Synchronous FIFO of requester tags for phases in flight inside the sincos core.
module sincos_tag_fifo
  import sincos_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  tag_t                       tag_i,
  output tag_t                       tag_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  tag_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign tag_o   = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= TAG_PLAYER;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= tag_i;
    end
  end

endmodule

// File: rtl/sincos_arbiter.sv
// Two-port front end for the shared sincos core: wraps, issues, and routes results by tag.
// SINCOS_ROUND_ROBIN_EN selects alternating tie grants; otherwise port 0 wins ties.
module sincos_arbiter
  import sincos_pkg::*;
#(
  parameter int unsigned PHASE_W         = PHASE_W_DEF,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic [PHASE_W-1:0] req0_phase,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [PHASE_W-1:0] req1_phase,
  input  logic               req1_valid,
  output logic               req1_ready,
  output logic [PHASE_W-1:0] core_phase,
  output logic               core_phase_tvalid,
  input  logic [PHASE_W-1:0] core_sin,
  input  logic [PHASE_W-1:0] core_cos,
  input  logic               core_tvalid,
  output logic [PHASE_W-1:0] resp0_sin,
  output logic [PHASE_W-1:0] resp0_cos,
  output logic               resp0_valid,
  output logic [PHASE_W-1:0] resp1_sin,
  output logic [PHASE_W-1:0] resp1_cos,
  output logic               resp1_valid,
  output logic               busy,
  output logic               err_underflow
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic               fifo_empty, fifo_full;
  logic [CNT_W-1:0]   fifo_count;
  tag_t               push_tag, pop_tag;
  logic               grant0, grant1, accept, pop;
  logic [PHASE_W-1:0] sel_phase;

  logic [PHASE_W-1:0] core_phase_q, core_phase_d;
  logic               core_valid_q, core_valid_d;
  logic [PHASE_W-1:0] resp0_sin_q, resp0_sin_d, resp0_cos_q, resp0_cos_d;
  logic [PHASE_W-1:0] resp1_sin_q, resp1_sin_d, resp1_cos_q, resp1_cos_d;
  logic               resp0_valid_q, resp0_valid_d, resp1_valid_q, resp1_valid_d;
  logic               err_q, err_d;
`ifdef SINCOS_ROUND_ROBIN_EN
  logic               rr_q, rr_d;
`endif

  // Grant from the valids, gated by the registered outstanding count
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!fifo_full) begin
`ifdef SINCOS_ROUND_ROBIN_EN
      if (req0_valid && req1_valid) begin
        grant0 = rr_q;
        grant1 = ~rr_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
`else
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
`endif
    end
  end

  assign accept    = grant0 | grant1;
  assign push_tag  = grant1 ? TAG_RAY : TAG_PLAYER;
  assign sel_phase = grant1 ? req1_phase : req0_phase;
  assign pop       = core_tvalid & ~fifo_empty;

  sincos_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (CLK),
    .rst_n   (RESETN),
    .push_i  (accept),
    .pop_i   (pop),
    .tag_i   (push_tag),
    .tag_o   (pop_tag),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  always_comb begin
    core_phase_d  = core_phase_q;
    core_valid_d  = accept;
    resp0_sin_d   = resp0_sin_q;
    resp0_cos_d   = resp0_cos_q;
    resp1_sin_d   = resp1_sin_q;
    resp1_cos_d   = resp1_cos_q;
    resp0_valid_d = 1'b0;
    resp1_valid_d = 1'b0;
    err_d         = err_q | (core_tvalid & fifo_empty);
`ifdef SINCOS_ROUND_ROBIN_EN
    rr_d          = rr_q ^ (accept & req0_valid & req1_valid);
`endif
    if (accept) core_phase_d = PHASE_W'(wrap_phase(PHASE_W_DEF'(sel_phase)));
    if (pop) begin
      if (pop_tag == TAG_RAY) begin
        resp1_sin_d   = core_sin;
        resp1_cos_d   = core_cos;
        resp1_valid_d = 1'b1;
      end else begin
        resp0_sin_d   = core_sin;
        resp0_cos_d   = core_cos;
        resp0_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      core_phase_q  <= '0;
      core_valid_q  <= 1'b0;
      resp0_sin_q   <= '0;
      resp0_cos_q   <= '0;
      resp1_sin_q   <= '0;
      resp1_cos_q   <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      err_q         <= 1'b0;
`ifdef SINCOS_ROUND_ROBIN_EN
      rr_q          <= 1'b1;
`endif
    end else begin
      core_phase_q  <= core_phase_d;
      core_valid_q  <= core_valid_d;
      resp0_sin_q   <= resp0_sin_d;
      resp0_cos_q   <= resp0_cos_d;
      resp1_sin_q   <= resp1_sin_d;
      resp1_cos_q   <= resp1_cos_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      err_q         <= err_d;
`ifdef SINCOS_ROUND_ROBIN_EN
      rr_q          <= rr_d;
`endif
    end
  end

  assign req0_ready        = grant0;
  assign req1_ready        = grant1;
  assign core_phase        = core_phase_q;
  assign core_phase_tvalid = core_valid_q;
  assign resp0_sin         = resp0_sin_q;
  assign resp0_cos         = resp0_cos_q;
  assign resp0_valid       = resp0_valid_q;
  assign resp1_sin         = resp1_sin_q;
  assign resp1_cos         = resp1_cos_q;
  assign resp1_valid       = resp1_valid_q;
  assign busy              = (fifo_count != '0);
  assign err_underflow     = err_q;

endmodule

// File: tb/tb_sincos_arbiter.sv
// Scoreboard bench for sincos_arbiter with a variable-latency stub core.
module tb_sincos_arbiter;

  localparam int unsigned PW   = 16;
  localparam int unsigned MAXO = 8;

  logic          CLK = 1'b0;
  logic          RESETN = 1'b0;
  logic [PW-1:0] req0_phase = '0, req1_phase = '0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [PW-1:0] core_phase, core_sin, core_cos;
  logic          core_phase_tvalid, core_tvalid;
  logic [PW-1:0] resp0_sin, resp0_cos, resp1_sin, resp1_cos;
  logic          resp0_valid, resp1_valid, busy, err_underflow;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;

  sincos_arbiter #(.PHASE_W(PW), .MAX_OUTSTANDING(MAXO)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .req0_phase(req0_phase), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_phase(req1_phase), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .core_phase(core_phase), .core_phase_tvalid(core_phase_tvalid),
    .core_sin(core_sin), .core_cos(core_cos), .core_tvalid(core_tvalid),
    .resp0_sin(resp0_sin), .resp0_cos(resp0_cos), .resp0_valid(resp0_valid),
    .resp1_sin(resp1_sin), .resp1_cos(resp1_cos), .resp1_valid(resp1_valid),
    .busy(busy), .err_underflow(err_underflow)
  );

  function automatic logic [15:0] stub_sin(input logic [15:0] p);
    return p ^ 16'hA5A5;
  endfunction
  function automatic logic [15:0] stub_cos(input logic [15:0] p);
    return p + 16'h1357;
  endfunction

  // Stub core: in-order delay line, held in reset with the arbiter
  int          core_lat = 10;
  logic        inj = 1'b0;
  logic        pv [32];
  logic [15:0] pp [32];
  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < 32; i++) begin pv[i] <= 1'b0; pp[i] <= '0; end
    end else begin
      pv[0] <= core_phase_tvalid;
      pp[0] <= core_phase;
      for (int i = 1; i < 32; i++) begin pv[i] <= pv[i-1]; pp[i] <= pp[i-1]; end
    end
  end
  assign core_tvalid = pv[core_lat-1] | inj;
  assign core_sin    = stub_sin(pp[core_lat-1]);
  assign core_cos    = stub_cos(pp[core_lat-1]);

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference wrap in plain integer radians*8192
  function automatic logic [15:0] wrapm(input logic [15:0] ph);
    int p;
    p = int'($signed(ph));
    if (p > 25736) p -= 51472;
    else if (p < -25736) p += 51472;
    return 16'(p);
  endfunction

  // Requester drivers: hold valid/phase until accepted
  logic [15:0] q0[$], q1[$];
  logic        acc0 = 1'b0, acc1 = 1'b0;
  always @(posedge CLK) begin
    #1;
    if (!RESETN) req0_valid = 1'b0;
    else if (!req0_valid || acc0) begin
      if (q0.size() > 0) begin req0_phase = q0.pop_front(); req0_valid = 1'b1; end
      else req0_valid = 1'b0;
    end
  end
  always @(posedge CLK) begin
    #1;
    if (!RESETN) req1_valid = 1'b0;
    else if (!req1_valid || acc1) begin
      if (q1.size() > 0) begin req1_phase = q1.pop_front(); req1_valid = 1'b1; end
      else req1_valid = 1'b0;
    end
  end

  // Reference model state
  typedef struct { logic tag; logic [15:0] ph; int cyc; } infl_t;
  infl_t       infl[$];
  infl_t       ent;
  int          cnt_m = 0;
  logic        err_m = 1'b0, rr_m = 1'b1;
  logic        e_iss_v = 1'b0, e_r0_v = 1'b0, e_r1_v = 1'b0;
  logic [15:0] e_iss_p = '0, e_r0_s = '0, e_r0_c = '0, e_r1_s = '0, e_r1_c = '0;
  logic        room, er0, er1;

  // Monitor / scoreboard, sampled mid-cycle
  always @(negedge CLK) begin
    cyc++;
    if (!RESETN) begin
      chk("rst_ctl", {91'd0, core_phase_tvalid, resp0_valid, resp1_valid, busy, err_underflow}, '0);
      chk("rst_data", {16'd0, core_phase, resp0_sin, resp0_cos, resp1_sin, resp1_cos}, '0);
      infl.delete();
      cnt_m = 0; err_m = 1'b0; rr_m = 1'b1;
      e_iss_v = 1'b0; e_r0_v = 1'b0; e_r1_v = 1'b0;
      acc0 = 1'b0; acc1 = 1'b0;
    end else begin
      chk("issue_valid", 96'(core_phase_tvalid), 96'(e_iss_v));
      if (e_iss_v) chk("core_phase", 96'(core_phase), 96'(e_iss_p));
      chk("resp0_valid", 96'(resp0_valid), 96'(e_r0_v));
      chk("resp1_valid", 96'(resp1_valid), 96'(e_r1_v));
      if (e_r0_v) chk("resp0_data", {64'd0, resp0_sin, resp0_cos}, {64'd0, e_r0_s, e_r0_c});
      if (e_r1_v) chk("resp1_data", {64'd0, resp1_sin, resp1_cos}, {64'd0, e_r1_s, e_r1_c});
      chk("busy", 96'(busy), 96'(cnt_m != 0));
      chk("err_underflow", 96'(err_underflow), 96'(err_m));

      room = (cnt_m < int'(MAXO));
`ifdef SINCOS_ROUND_ROBIN_EN
      er0 = room && req0_valid && (!req1_valid || rr_m);
      er1 = room && req1_valid && (!req0_valid || !rr_m);
      if (room && req0_valid && req1_valid) rr_m = ~rr_m;
`else
      er0 = room && req0_valid;
      er1 = room && req1_valid && !req0_valid;
`endif
      chk("req0_ready", 96'(req0_ready), 96'(er0));
      chk("req1_ready", 96'(req1_ready), 96'(er1));
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;

      e_r0_v = 1'b0; e_r1_v = 1'b0;
      if (core_tvalid) begin
        if (infl.size() > 0) begin
          ent = infl.pop_front();
          chk("latency", 96'(cyc - ent.cyc), 96'(core_lat + 1));
          if (ent.tag) begin e_r1_v = 1'b1; e_r1_s = stub_sin(ent.ph); e_r1_c = stub_cos(ent.ph); end
          else         begin e_r0_v = 1'b1; e_r0_s = stub_sin(ent.ph); e_r0_c = stub_cos(ent.ph); end
          cnt_m--;
        end else begin
          err_m = 1'b1;
        end
      end

      e_iss_v = er0 | er1;
      if (e_iss_v) begin
        e_iss_p = wrapm(er1 ? req1_phase : req0_phase);
        infl.push_back('{tag: er1, ph: e_iss_p, cyc: cyc});
        cnt_m++;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req0_valid || req1_valid || infl.size() > 0) && n < 3000) begin
      @(posedge CLK);
      n++;
    end
    vectors++;
    if (n >= 3000) begin
      miscompares++;
      $display("FAIL idle_timeout: waited %0d cycles, limit 3000", n);
    end
    repeat (34) @(posedge CLK);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #2 RESETN = 1'b1;
    repeat (2) @(posedge CLK);

    // Directed phases, including wrap boundaries
    q0.push_back(16'h2000); wait_idle();
    q0.push_back(16'h7000); wait_idle();
    q1.push_back(16'h8000); wait_idle();
    q0.push_back(16'h6488); q0.push_back(16'h6489); q1.push_back(16'h9B78);
    q1.push_back(16'h9B77); q0.push_back(16'h7FFF); wait_idle();

    // Six-cycle tie
    for (int i = 0; i < 6; i++) begin
      q0.push_back(16'($urandom)); q1.push_back(16'($urandom));
    end
    wait_idle();

    // Fill to MAX_OUTSTANDING with a long core latency
    core_lat = 20;
    for (int i = 0; i < 12; i++) q1.push_back(16'($urandom));
    wait_idle();
    core_lat = 10;

    // Interleaved tags 0,1,1,0
    q0.push_back(16'h1111); @(posedge CLK);
    q1.push_back(16'h2222); @(posedge CLK);
    q1.push_back(16'h3333); @(posedge CLK);
    q0.push_back(16'h4444);
    wait_idle();

    // Random traffic at varied core latencies
    for (int r = 0; r < 4; r++) begin
      core_lat = $urandom_range(24, 1);
      for (int c = 0; c < 100; c++) begin
        if ($urandom_range(2, 0) == 0) q0.push_back(16'($urandom));
        if ($urandom_range(1, 0) == 0) q1.push_back(16'($urandom));
        @(posedge CLK);
      end
      wait_idle();
    end
    core_lat = 10;

    // Spurious core result with nothing outstanding
    @(posedge CLK); #1 inj = 1'b1;
    @(posedge CLK); #1 inj = 1'b0;
    repeat (5) @(posedge CLK);

    // Reset in the middle of a burst
    for (int i = 0; i < 10; i++) begin
      q0.push_back(16'($urandom)); q1.push_back(16'($urandom));
    end
    repeat (6) @(posedge CLK);
    #2 RESETN = 1'b0;
    q0.delete(); q1.delete();
    repeat (3) @(posedge CLK);
    #2 RESETN = 1'b1;
    wait_idle();
    q1.push_back(16'hC000); q0.push_back(16'h4000);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
